// File: rtl/fns_enc_seq_16_pkg.sv
// fns_enc_seq_16_pkg: shared FNS weights, widths and encoder state encoding.
package fns_enc_seq_16_pkg;
    localparam int CW_BITS = 16;
    localparam int FBLEN16 = 13;
    localparam int DW = FBLEN16;
    localparam logic [DW-1:0] FNS_MAX16 = 13'd2583;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    // FNS01..FNS16, index 0 is the weight of codeword bit 0
    localparam logic [DW-1:0] FNS_W [CW_BITS] = '{
        13'd1, 13'd2, 13'd3, 13'd5, 13'd8, 13'd13, 13'd21, 13'd34,
        13'd55, 13'd89, 13'd144, 13'd233, 13'd377, 13'd610, 13'd987, 13'd1597
    };
endpackage

// File: rtl/fns_weight_sel_16.sv
// fns_weight_sel_16: combinational bit-index to FNS weight lookup.
module fns_weight_sel_16
    import fns_enc_seq_16_pkg::*;
(
    input  logic [3:0]    idx,
    output logic [DW-1:0] weight
);
    assign weight = FNS_W[idx];
endmodule

// File: rtl/fns_enc_seq_16.sv
// fns_enc_seq_16: greedy MSB-first Zeckendorf encoder, one codeword bit per cycle.
module fns_enc_seq_16
    import fns_enc_seq_16_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DW-1:0]      in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [CW_BITS-1:0] out_code,
    output logic               out_err,
    output logic               out_valid,
    input  logic               out_ready
);
    state_t state, state_next;
    logic [DW-1:0] rem, weight;
    logic [3:0] idx;
    logic take, too_big;

    fns_weight_sel_16 u_wsel (.idx(idx), .weight(weight));

    assign too_big   = in_data > FNS_MAX16;
    assign take      = rem >= weight;
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = in_valid ? (too_big ? DONE : RUN) : IDLE;
            RUN:     state_next = (idx == 4'd0) ? DONE : RUN;
            DONE:    state_next = out_ready ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            out_code <= '0;
            out_err  <= 1'b0;
            idx      <= 4'd15;
        end else if (state == IDLE && in_valid) begin
            rem      <= too_big ? '0 : in_data;
            out_code <= '0;
            out_err  <= too_big;
            idx      <= 4'd15;
        end else if (state == RUN) begin
            // taking the largest fitting weight guarantees no adjacent ones
            out_code[idx] <= take;
            rem           <= take ? rem - weight : rem;
            idx           <= idx - 4'd1;
        end
    end
endmodule

// File: tb/tb_fns_enc_seq_16.sv
// tb_fns_enc_seq_16: vector table, exhaustive/random model checks, backpressure and reset sequences.
module tb_fns_enc_seq_16;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [12:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_code;
    logic        out_err;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    fns_enc_seq_16 dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_code(out_code), .out_err(out_err),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] din;
        logic [15:0] code;
        logic        err;
        int          ofs;
    } vec_t;

    function automatic void check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endfunction

    // Fibonacci weights generated by recurrence: fib[i] = weight of bit i, fib[16] = first unrepresentable value
    function automatic int fib(input int i);
        int a = 1, b = 2, t;
        for (int k = 0; k < i; k++) begin
            t = a + b; a = b; b = t;
        end
        return a;
    endfunction

    function automatic logic [16:0] ref_encode(input int v);
        logic [15:0] c = '0;
        int r = v;
        if (v >= fib(16)) return {1'b1, 16'h0};
        for (int i = 15; i >= 0; i--)
            if (r >= fib(i)) begin
                c[i] = 1'b1;
                r -= fib(i);
            end
        return {1'b0, c};
    endfunction

    function automatic int decode(input logic [15:0] c);
        int s = 0;
        for (int i = 0; i < 16; i++) if (c[i]) s += fib(i);
        return s;
    endfunction

    // Encode v; hold out_ready low for stall cycles in DONE, optionally poking in_valid meanwhile
    task automatic encode(input logic [12:0] v, input int stall, input bit poke,
                          output logic [15:0] c, output logic e, output int ofs);
        int n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        @(negedge clk);
        in_data = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        ofs = 0;
        while (!out_valid && ofs < 40) begin @(posedge clk); #1; ofs++; end
        if (!out_valid) check("out_valid_timeout", 0, 1);
        c = out_code;
        e = out_err;
        if (poke) begin
            in_data = 13'd42;
            in_valid = 1'b1;
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_code", int'(out_code), int'(c));
            check("stall_ready", int'(in_ready), 0);
            check("stall_valid", int'(out_valid), 1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        if (poke) begin
            check("no_accept_in_done", int'(in_ready), 1);
            in_valid = 1'b0;
        end
    endtask

    vec_t vecs[9];
    logic [15:0] c;
    logic e;
    int ofs;
    logic [16:0] m;

    initial begin
        vecs[0] = '{13'd0,    16'h0000, 1'b0, 16};
        vecs[1] = '{13'd100,  16'h0214, 1'b0, 16};
        vecs[2] = '{13'd1597, 16'h8000, 1'b0, 16};
        vecs[3] = '{13'd2583, 16'hAAAA, 1'b0, 16};
        vecs[4] = '{13'd2584, 16'h0000, 1'b1, 0};
        vecs[5] = '{13'd8191, 16'h0000, 1'b1, 0};
        vecs[6] = '{13'd1,    16'h0001, 1'b0, 16};
        vecs[7] = '{13'd4,    16'h0005, 1'b0, 16};
        vecs[8] = '{13'd5,    16'h0008, 1'b0, 16};

        #12;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_code", int'(out_code), 0);
        check("rst_out_err", int'(out_err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            encode(vecs[i].din, 0, 1'b0, c, e, ofs);
            check($sformatf("vec%0d_code", i), int'(c), int'(vecs[i].code));
            check($sformatf("vec%0d_err", i), int'(e), int'(vecs[i].err));
            check($sformatf("vec%0d_ofs", i), ofs, vecs[i].ofs);
        end

        encode(13'd777, 10, 1'b1, c, e, ofs);
        m = ref_encode(777);
        check("bp_code", int'(c), int'(m[15:0]));
        encode(13'd33, 0, 1'b0, c, e, ofs);
        m = ref_encode(33);
        check("after_bp_code", int'(c), int'(m[15:0]));

        // abort mid-RUN with an asynchronous reset
        @(negedge clk);
        in_data = 13'd1000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_out_code", int'(out_code), 0);
        check("abort_out_err", int'(out_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        encode(13'd5, 0, 1'b0, c, e, ofs);
        check("post_abort_code", int'(c), 16'h0008);

        for (int v = 0; v <= 2583; v++) begin
            encode(v[12:0], 0, 1'b0, c, e, ofs);
            check($sformatf("exh%0d_dec", v), decode(c), v);
            check($sformatf("exh%0d_adj", v), int'((c & (c >> 1)) != 16'h0), 0);
            if (e) check($sformatf("exh%0d_err", v), int'(e), 0);
        end

        for (int n = 0; n < 150; n++) begin
            logic [12:0] v;
            int st;
            v = 13'($urandom_range(0, 8191));
            st = $urandom_range(0, 3);
            encode(v, st, 1'b0, c, e, ofs);
            m = ref_encode(int'(v));
            check($sformatf("rnd%0d_code", n), int'(c), int'(m[15:0]));
            check($sformatf("rnd%0d_err", n), int'(e), int'(m[16]));
            check($sformatf("rnd%0d_ofs", n), ofs, m[16] ? 0 : 16);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
